// File: rtl/mem_controller.sv
// Memory-side slave for 4-word bursts on the multiplexed 16-bit AddrData bus.
// Serves one 4K x 16 page; drives read beats, captures write beats.
module mem_controller #(
  parameter logic [3:0] PAGE     = 4'h0,
  parameter int         DEPTH    = 4096,
  parameter int         BURSTLEN = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        AddrValid,
  input  logic        rw,
  inout  wire  [15:0] AddrData,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] mem [DEPTH];

  logic [11:0] beat_addr;
  logic        last_beat;
  logic        hit;

  // Offset arithmetic wraps inside the page; it never carries into the page field.
  assign beat_addr = addr_q + {10'b0, cnt_q};
  assign last_beat = (cnt_q == 2'(BURSTLEN - 1));
  assign hit       = AddrValid && (AddrData[15:12] == PAGE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          addr_d  = AddrData[11:0];
          cnt_d   = 2'd0;
          state_d = rw ? RD : WR;
        end
      end
      RD, WR: begin
        // AddrValid is ignored here, including on the final beat edge.
        if (last_beat) begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 12'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // A write beat coinciding with a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (resetN && (state_q == WR)) begin
      mem[beat_addr] <= AddrData;
    end
  end

  // Output enable comes straight from the state register, so it cannot glitch.
  assign AddrData = (state_q == RD) ? mem[beat_addr] : 16'hzzzz;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller (PAGE=3): bursts, page filtering, wrap,
// reset mid-burst and ignored AddrValid while busy.
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        resetN;
  logic        av;
  logic        rw;
  logic        tb_oe;
  logic [15:0] tb_d;
  wire  [15:0] bus;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // The bench parks the bus at 0 whenever the controller must not drive it,
  // so any stray drive corrupts the observed value.
  assign bus = tb_oe ? tb_d : 16'hzzzz;

  mem_controller #(.PAGE(4'h3)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .AddrValid (av),
    .rw        (rw),
    .AddrData  (bus),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents the address for one cycle; returns just after the address edge.
  task automatic send_addr(input logic [15:0] a, input logic r);
    av = 1'b1; rw = r; tb_oe = 1'b1; tb_d = a;
    @(negedge clk);
    check("addr_busy", {15'b0, busy}, 16'h0000);
    check("addr_bus", bus, a);
    tick();
    av = 1'b0; rw = 1'b0;
  endtask

  task automatic write_burst(input logic [15:0] a, input logic [63:0] d, input logic mine);
    send_addr(a, 1'b0);
    for (int b = 0; b < 4; b++) begin
      tb_d = d[b*16 +: 16];
      @(negedge clk);
      check("wr_busy", {15'b0, busy}, {15'b0, mine});
      tick();
    end
    tb_d = 16'h0000;
  endtask

  task automatic read_burst(input logic [15:0] a, input logic [63:0] d, input logic mine, input int nchk);
    send_addr(a, 1'b1);
    for (int b = 0; b < 4; b++) begin
      if (mine) tb_oe = 1'b0;
      else      tb_d  = 16'h0000;
      @(negedge clk);
      if (b < nchk) check("rd_data", bus, mine ? d[b*16 +: 16] : 16'h0000);
      check("rd_busy", {15'b0, busy}, {15'b0, mine});
      tick();
    end
    tb_oe = 1'b1; tb_d = 16'h0000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy", {15'b0, busy}, 16'h0000);
      check("idle_bus", bus, 16'h0000);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; av = 1'b0; rw = 1'b0; tb_oe = 1'b1; tb_d = 16'h0000;
    tick(); tick();
    @(negedge clk);
    check("reset_busy", {15'b0, busy}, 16'h0000);
    check("reset_bus", bus, 16'h0000);
    resetN = 1'b1;
    tick();

    // Basic write then read in our page.
    write_burst(16'h3100, 64'h4444_3333_2222_1111, 1'b1);
    idle(2);
    read_burst(16'h3100, 64'h4444_3333_2222_1111, 1'b1, 4);
    idle(1);

    // Foreign page: ignored for both directions; page-3 data untouched.
    write_burst(16'h5100, 64'h9999_8888_7777_6666, 1'b0);
    idle(1);
    read_burst(16'h5100, 64'h0, 1'b0, 4);
    idle(1);
    read_burst(16'h3100, 64'h4444_3333_2222_1111, 1'b1, 4);
    idle(1);

    // Offset wrap at the top of the page.
    write_burst(16'h3FFE, 64'hDDDD_CCCC_BBBB_AAAA, 1'b1);
    idle(1);
    read_burst(16'h3FFE, 64'hDDDD_CCCC_BBBB_AAAA, 1'b1, 4);
    idle(1);
    read_burst(16'h3000, 64'h0000_0000_DDDD_CCCC, 1'b1, 2);
    idle(1);
    read_burst(16'h4FFE, 64'h0, 1'b0, 4);
    idle(1);
    read_burst(16'h3100, 64'h4444_3333_2222_1111, 1'b1, 4);
    idle(1);

    // Reset on the edge ending read beat 1.
    send_addr(16'h3100, 1'b1);
    tb_oe = 1'b0;
    @(negedge clk);
    check("rstrd_b0", bus, 16'h1111);
    tick();
    @(negedge clk);
    check("rstrd_b1", bus, 16'h2222);
    resetN = 1'b0;
    tick();
    resetN = 1'b1; tb_oe = 1'b1; tb_d = 16'h0000;
    @(negedge clk);
    check("rstrd_busy", {15'b0, busy}, 16'h0000);
    check("rstrd_bus", bus, 16'h0000);
    tick();
    read_burst(16'h3100, 64'h4444_3333_2222_1111, 1'b1, 4);
    idle(1);

    // Reset on the edge that would capture write beat 2.
    write_burst(16'h3200, 64'hF004_F003_F002_F001, 1'b1);
    idle(1);
    send_addr(16'h3200, 1'b0);
    tb_d = 16'h5555;
    tick();
    tb_d = 16'h6666;
    tick();
    tb_d = 16'h7777; resetN = 1'b0;
    tick();
    resetN = 1'b1; tb_d = 16'h8888;
    @(negedge clk);
    check("rstwr_busy", {15'b0, busy}, 16'h0000);
    tick();
    tb_d = 16'h0000;
    idle(1);
    read_burst(16'h3200, 64'hF004_F003_6666_5555, 1'b1, 4);
    idle(1);

    // AddrValid during read beat 2 (bus shows 3333, a page-3 address) is ignored.
    send_addr(16'h3100, 1'b1);
    tb_oe = 1'b0;
    for (int b = 0; b < 4; b++) begin
      av = (b == 2); rw = 1'b0;
      @(negedge clk);
      check("viol_rd", bus, 16'h1111 * 16'(b + 1));
      check("viol_busy", {15'b0, busy}, 16'h0001);
      tick();
    end
    av = 1'b0; tb_oe = 1'b1; tb_d = 16'h0000;
    idle(1);

    // AddrValid during write beats 2..3, including the back-to-back edge k+4.
    send_addr(16'h3400, 1'b0);
    for (int b = 0; b < 4; b++) begin
      tb_d = 16'h3100 + 16'(b * 16'h0100);
      av = (b >= 2); rw = 1'b1;
      @(negedge clk);
      check("viol_wr_busy", {15'b0, busy}, 16'h0001);
      tick();
    end
    av = 1'b0; rw = 1'b0;
    // Request at k+5 must be accepted.
    read_burst(16'h3400, 64'h3400_3300_3200_3100, 1'b1, 4);
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
